// File: rtl/hall_call_pkg.sv
// Shared types for the hall-call front end: call direction, the queued request
// record and the floor-index width helper.
package hall_call_pkg;

   typedef enum logic {
      DIR_DOWN = 1'b0,
      DIR_UP   = 1'b1
   } dir_e;

   // Queued records carry a fixed-width floor field; the top narrows it to its own FLOOR_W.
   localparam int FLOOR_W_MAX = 8;

   typedef struct packed {
      logic [FLOOR_W_MAX-1:0] floor;
      dir_e                   dir;
   } hall_req_t;

   function automatic int floorWidth(input int nFloors);
      return (nFloors > 1) ? $clog2(nFloors) : 1;
   endfunction

endpackage

// File: rtl/hall_call_request_queue_debouncer.sv
// One hall button: two-flop synchroniser, debounce counter, debounced level and
// a registered one-cycle pulse on each debounced 0->1 transition.
module hall_button_debouncer #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic raw_i,
   output logic rise_o
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

   logic             sync1_q, sync2_q;
   logic             level_q, level_d;
   logic             rise_q, rise_d;
   logic [CNT_W-1:0] count_q, count_d;

   // The level flips on the DEBOUNCE_CYCLES-th consecutive differing sample.
   always_comb begin
      level_d = level_q;
      count_d = '0;
      rise_d  = 1'b0;
      if (sync2_q != level_q) begin
         if (count_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            level_d = sync2_q;
            rise_d  = sync2_q;
         end else begin
            count_d = count_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         count_q <= '0;
      end else begin
         sync1_q <= raw_i;
         sync2_q <= sync1_q;
         level_q <= level_d;
         rise_q  <= rise_d;
         count_q <= count_d;
      end
   end

   assign rise_o = rise_q;

endmodule

// File: rtl/hall_call_request_queue.sv
// Hall-call front end: debounces every hall button, latches presses into lamp and
// pending bitmaps, and feeds the arbiter from a round-robin-filled request FIFO.
module hall_call_request_queue
   import hall_call_pkg::*;
#(
   parameter int  N_FLOORS        = 12,
   parameter int  DEBOUNCE_CYCLES = 4,
   parameter int  FIFO_DEPTH      = 8,
   localparam int FLOOR_W         = floorWidth(N_FLOORS)
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic [N_FLOORS-1:0] btn_up_i,
   input  logic [N_FLOORS-1:0] btn_down_i,
   output logic               req_valid_o,
   input  logic               req_ready_i,
   output logic [FLOOR_W-1:0] req_floor_o,
   output logic               req_dir_o,
   input  logic               serviced_valid_i,
   input  logic [FLOOR_W-1:0] serviced_floor_i,
   input  logic               serviced_dir_i,
   output logic [N_FLOORS-1:0] lamp_up_o,
   output logic [N_FLOORS-1:0] lamp_down_o
);

   localparam int NSRC  = 2 * N_FLOORS;
   localparam int SRC_W = FLOOR_W + 1;
   localparam int PTR_W = $clog2(FIFO_DEPTH);

   logic [N_FLOORS-1:0] upRise, downRise;
   logic [NSRC-1:0]     srcRise, svcMask, newPress, pushCand, pushMask;
   logic [NSRC-1:0]     lamp_q, lamp_d, pending_q, pending_d;
   logic [SRC_W-1:0]    rrPtr_q, rrPtr_d, svcIdx, selIdx, headIdx;
   logic [PTR_W:0]      wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
   logic                selFound, fifoEmpty, fifoFull, headLit, doPush, doPop;
   int                  rrIdx;
   hall_req_t           fifoMem_q [FIFO_DEPTH];
   hall_req_t           headReq, pushReq;

   // Source index is 2*floor + dir; the top-floor up and floor-0 down buttons never raise an event.
   for (genvar f = 0; f < N_FLOORS; f++) begin : g_floor
      hall_button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
         .clk_i  (clk_i),
         .rst_ni (rst_ni),
         .raw_i  (btn_up_i[f]),
         .rise_o (upRise[f])
      );
      hall_button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down (
         .clk_i  (clk_i),
         .rst_ni (rst_ni),
         .raw_i  (btn_down_i[f]),
         .rise_o (downRise[f])
      );
      assign srcRise[2*f+1] = upRise[f] & (f != N_FLOORS - 1);
      assign srcRise[2*f]   = downRise[f] & (f != 0);
   end

   // A serviced strobe beats a press on the same source in the same cycle.
   always_comb begin
      svcIdx  = {serviced_floor_i, serviced_dir_i};
      svcMask = '0;
      for (int s = 0; s < NSRC; s++) begin
         svcMask[s] = serviced_valid_i && (svcIdx == SRC_W'(s));
      end
      newPress = srcRise & ~lamp_q & ~svcMask;
      pushCand = pending_q & ~svcMask;
   end

   // Round-robin search begins one past the last pushed source and ends on it.
   always_comb begin
      selFound = 1'b0;
      selIdx   = rrPtr_q;
      rrIdx    = 0;
      for (int k = 1; k <= NSRC; k++) begin
         rrIdx = int'(rrPtr_q) + k;
         if (rrIdx >= NSRC) begin
            rrIdx = rrIdx - NSRC;
         end
         if (!selFound && pushCand[rrIdx]) begin
            selFound = 1'b1;
            selIdx   = SRC_W'(rrIdx);
         end
      end
   end

   always_comb begin
      fifoEmpty = (wrPtr_q == rdPtr_q);
      fifoFull  = (wrPtr_q[PTR_W] != rdPtr_q[PTR_W]) &&
                  (wrPtr_q[PTR_W-1:0] == rdPtr_q[PTR_W-1:0]);
      headReq   = fifoMem_q[rdPtr_q[PTR_W-1:0]];
      headIdx   = {FLOOR_W'(headReq.floor), headReq.dir};
      headLit   = lamp_q[headIdx];
      // A head whose lamp has gone dark was serviced while queued and is dropped unseen.
      doPop     = !fifoEmpty && (!headLit || req_ready_i);
      doPush    = selFound && (!fifoFull || doPop);

      pushMask = '0;
      if (doPush) begin
         pushMask[selIdx] = 1'b1;
      end
      pushReq       = '0;
      pushReq.floor = FLOOR_W_MAX'(selIdx[SRC_W-1:1]);
      pushReq.dir   = dir_e'(selIdx[0]);

      lamp_d    = (lamp_q | newPress) & ~svcMask;
      pending_d = (pending_q | newPress) & ~svcMask & ~pushMask;
      rrPtr_d   = doPush ? selIdx : rrPtr_q;
      wrPtr_d   = wrPtr_q + (PTR_W + 1)'(doPush);
      rdPtr_d   = rdPtr_q + (PTR_W + 1)'(doPop);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         lamp_q    <= '0;
         pending_q <= '0;
         rrPtr_q   <= '0;
         wrPtr_q   <= '0;
         rdPtr_q   <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifoMem_q[i] <= '0;
         end
      end else begin
         lamp_q    <= lamp_d;
         pending_q <= pending_d;
         rrPtr_q   <= rrPtr_d;
         wrPtr_q   <= wrPtr_d;
         rdPtr_q   <= rdPtr_d;
         if (doPush) begin
            fifoMem_q[wrPtr_q[PTR_W-1:0]] <= pushReq;
         end
      end
   end

   always_comb begin
      req_valid_o = !fifoEmpty && headLit;
      req_floor_o = FLOOR_W'(headReq.floor);
      req_dir_o   = headReq.dir;
      lamp_up_o   = '0;
      lamp_down_o = '0;
      for (int f = 0; f < N_FLOORS; f++) begin
         lamp_up_o[f]   = lamp_q[2*f+1];
         lamp_down_o[f] = lamp_q[2*f];
      end
   end

endmodule

// File: tb/tb_hall_call_request_queue.sv
// Directed bench for hall_call_request_queue: a table of timed input phases with
// hand-computed outputs, then sequences for FIFO fill, stale purge and reset.
module tb_hall_call_request_queue;

   localparam int N_FLOORS        = 12;
   localparam int DEBOUNCE_CYCLES = 4;
   localparam int FIFO_DEPTH      = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [11:0] btnUp, btnDown, lampUp, lampDown;
   logic        reqValid, reqReady, reqDir;
   logic [3:0]  reqFloor;
   logic        svcValid, svcDir;
   logic [3:0]  svcFloor;

   int testsRun    = 0;
   int testsFailed = 0;

   typedef struct {
      string       name;
      logic [11:0] btnUp;
      logic [11:0] btnDown;
      logic        ready;
      logic        svcValid;
      logic [3:0]  svcFloor;
      logic        svcDir;
      int          cycles;
      logic        expValid;
      logic [3:0]  expFloor;
      logic        expDir;
      logic [11:0] expLampUp;
      logic [11:0] expLampDown;
   } vec_t;

   vec_t vecs[$];

   always #5 clk = ~clk;

   hall_call_request_queue #(
      .N_FLOORS        (N_FLOORS),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .FIFO_DEPTH      (FIFO_DEPTH)
   ) dut (
      .clk_i            (clk),
      .rst_ni           (rst_n),
      .btn_up_i         (btnUp),
      .btn_down_i       (btnDown),
      .req_valid_o      (reqValid),
      .req_ready_i      (reqReady),
      .req_floor_o      (reqFloor),
      .req_dir_o        (reqDir),
      .serviced_valid_i (svcValid),
      .serviced_floor_i (svcFloor),
      .serviced_dir_i   (svcDir),
      .lamp_up_o        (lampUp),
      .lamp_down_o      (lampDown)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [11:0] up, input logic [11:0] down, input logic rdy,
                                input logic sv, input logic [3:0] svF, input logic svD);
      btnUp    = up;
      btnDown  = down;
      reqReady = rdy;
      svcValid = sv;
      svcFloor = svF;
      svcDir   = svD;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic addVec(input string name, input logic [11:0] up, input logic [11:0] down,
                         input logic rdy, input logic sv, input logic [3:0] svF, input logic svD,
                         input int cyc, input logic eV, input logic [3:0] eF, input logic eD,
                         input logic [11:0] eLU, input logic [11:0] eLD);
      vec_t v;
      v.name = name; v.btnUp = up; v.btnDown = down; v.ready = rdy;
      v.svcValid = sv; v.svcFloor = svF; v.svcDir = svD; v.cycles = cyc;
      v.expValid = eV; v.expFloor = eF; v.expDir = eD;
      v.expLampUp = eLU; v.expLampDown = eLD;
      vecs.push_back(v);
   endtask

   task automatic checkHead(input string name, input logic eV, input logic [3:0] eF, input logic eD);
      checkOutput({name, "_valid"}, 32'(reqValid), 32'(eV));
      if (eV) begin
         checkOutput({name, "_floor"}, 32'(reqFloor), 32'(eF));
         checkOutput({name, "_dir"}, 32'(reqDir), 32'(eD));
      end
   endtask

   initial begin
      logic [4:0] got [5];
      logic [4:0] expOrder [5];
      int         nGot;

      applyStimulus('0, '0, 1'b0, 1'b0, 4'd0, 1'b0);
      rst_n = 1'b0;
      #2;
      checkOutput("reset_async_valid", 32'(reqValid), 32'd0);
      checkOutput("reset_async_lamps", 32'({lampUp, lampDown}), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Press on floor 3 up reaches lamp on the 7th edge counting the first sampling edge.
      addVec("idle",               12'h000, 12'h000, 1, 0, 0, 0,  1, 0, 0, 0, 12'h000, 12'h000);
      addVec("f3up_debouncing",    12'h008, 12'h000, 1, 0, 0, 0,  6, 0, 0, 0, 12'h000, 12'h000);
      addVec("f3up_lamp",          12'h008, 12'h000, 1, 0, 0, 0,  1, 0, 0, 0, 12'h008, 12'h000);
      addVec("f3up_valid",         12'h008, 12'h000, 1, 0, 0, 0,  1, 1, 3, 1, 12'h008, 12'h000);
      addVec("f3up_transferred",   12'h008, 12'h000, 1, 0, 0, 0,  2, 0, 0, 0, 12'h008, 12'h000);
      addVec("f3up_release",       12'h000, 12'h000, 1, 0, 0, 0,  6, 0, 0, 0, 12'h008, 12'h000);
      addVec("f3up_repress_lit",   12'h008, 12'h000, 1, 0, 0, 0,  9, 0, 0, 0, 12'h008, 12'h000);
      addVec("f5dn_glitch",        12'h000, 12'h020, 1, 0, 0, 0,  3, 0, 0, 0, 12'h008, 12'h000);
      addVec("f5dn_glitch_settle", 12'h000, 12'h000, 1, 0, 0, 0,  8, 0, 0, 0, 12'h008, 12'h000);
      addVec("f3up_serviced",      12'h000, 12'h000, 1, 1, 3, 1,  1, 0, 0, 0, 12'h000, 12'h000);
      addVec("f4up_debouncing",    12'h010, 12'h000, 1, 0, 0, 0,  6, 0, 0, 0, 12'h000, 12'h000);
      addVec("f4up_press_and_svc", 12'h010, 12'h000, 1, 1, 4, 1,  1, 0, 0, 0, 12'h000, 12'h000);
      addVec("f4up_discarded",     12'h010, 12'h000, 1, 0, 0, 0,  4, 0, 0, 0, 12'h000, 12'h000);
      addVec("ignored_buttons",    12'h800, 12'h001, 1, 0, 0, 0, 10, 0, 0, 0, 12'h000, 12'h000);
      addVec("quiet",              12'h000, 12'h000, 1, 0, 0, 0,  7, 0, 0, 0, 12'h000, 12'h000);

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].btnUp, vecs[i].btnDown, vecs[i].ready,
                       vecs[i].svcValid, vecs[i].svcFloor, vecs[i].svcDir);
         repeat (vecs[i].cycles) tick();
         checkHead(vecs[i].name, vecs[i].expValid, vecs[i].expFloor, vecs[i].expDir);
         checkOutput({vecs[i].name, "_lampUp"}, 32'(lampUp), 32'(vecs[i].expLampUp));
         checkOutput({vecs[i].name, "_lampDown"}, 32'(lampDown), 32'(vecs[i].expLampDown));
      end

      // Five simultaneous presses; last push was source 7, so order is 12,19,22,2 then 5.
      applyStimulus(12'h204, 12'h842, 1'b0, 1'b0, 4'd0, 1'b0);
      repeat (12) tick();
      checkHead("rr_full_head", 1'b1, 4'd6, 1'b0);
      checkOutput("rr_full_lampUp", 32'(lampUp), 32'h204);
      checkOutput("rr_full_lampDown", 32'(lampDown), 32'h842);
      applyStimulus('0, '0, 1'b0, 1'b0, 4'd0, 1'b0);
      repeat (3) tick();
      checkHead("rr_hold_head", 1'b1, 4'd6, 1'b0);

      expOrder[0] = {4'd6, 1'b0};
      expOrder[1] = {4'd9, 1'b1};
      expOrder[2] = {4'd11, 1'b0};
      expOrder[3] = {4'd1, 1'b0};
      expOrder[4] = {4'd2, 1'b1};
      nGot = 0;
      reqReady = 1'b1;
      for (int c = 0; c < 20; c++) begin
         if (reqValid) begin
            if (nGot < 5) begin
               got[nGot] = {reqFloor, reqDir};
            end
            nGot++;
         end
         tick();
      end
      checkOutput("rr_drain_count", 32'(nGot), 32'd5);
      for (int i = 0; i < 5; i++) begin
         if (i < nGot) begin
            checkOutput($sformatf("rr_drain_%0d", i), 32'(got[i]), 32'(expOrder[i]));
         end
      end
      checkOutput("rr_drain_empty", 32'(reqValid), 32'd0);
      reqReady = 1'b0;
      for (int i = 0; i < 5; i++) begin
         applyStimulus('0, '0, 1'b0, 1'b1, expOrder[i][4:1], expOrder[i][0]);
         tick();
      end
      applyStimulus('0, '0, 1'b0, 1'b0, 4'd0, 1'b0);
      tick();
      checkOutput("rr_svc_lamps", 32'({lampUp, lampDown}), 32'd0);

      // Queue {2,DOWN} then {7,UP}; servicing the head purges it silently.
      applyStimulus(12'h000, 12'h004, 1'b0, 1'b0, 4'd0, 1'b0);
      repeat (8) tick();
      applyStimulus(12'h080, 12'h000, 1'b0, 1'b0, 4'd0, 1'b0);
      repeat (8) tick();
      checkHead("stale_head_before", 1'b1, 4'd2, 1'b0);
      applyStimulus(12'h000, 12'h000, 1'b0, 1'b1, 4'd2, 1'b0);
      tick();
      checkOutput("stale_valid_drop", 32'(reqValid), 32'd0);
      checkOutput("stale_lampDown", 32'(lampDown), 32'h000);
      checkOutput("stale_lampUp", 32'(lampUp), 32'h080);
      applyStimulus(12'h000, 12'h000, 1'b0, 1'b0, 4'd0, 1'b0);
      tick();
      checkHead("stale_next_head", 1'b1, 4'd7, 1'b1);
      reqReady = 1'b1;
      tick();
      checkOutput("stale_drained", 32'(reqValid), 32'd0);
      applyStimulus(12'h000, 12'h000, 1'b0, 1'b1, 4'd7, 1'b1);
      tick();
      applyStimulus(12'h000, 12'h000, 1'b0, 1'b0, 4'd0, 1'b0);
      repeat (6) tick();

      // Reset mid-handshake with three queued calls; floor 8 down stays held throughout.
      applyStimulus(12'h401, 12'h100, 1'b0, 1'b0, 4'd0, 1'b0);
      repeat (10) tick();
      checkOutput("rst_pre_valid", 32'(reqValid), 32'd1);
      checkOutput("rst_pre_lamps", 32'({lampUp, lampDown}), 32'({12'h401, 12'h100}));
      reqReady = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("rst_mid_valid", 32'(reqValid), 32'd0);
      checkOutput("rst_mid_lamps", 32'({lampUp, lampDown}), 32'd0);
      applyStimulus(12'h000, 12'h100, 1'b0, 1'b0, 4'd0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (6) tick();
      checkOutput("rst_post_empty", 32'(reqValid), 32'd0);
      checkOutput("rst_post_lamps", 32'({lampUp, lampDown}), 32'd0);
      tick();
      checkOutput("rst_held_lamp", 32'(lampDown), 32'h100);
      checkOutput("rst_held_novalid", 32'(reqValid), 32'd0);
      tick();
      checkHead("rst_held_head", 1'b1, 4'd8, 1'b0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
